mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched.sv | 130 +++++++++++++
 tb/tb_mult_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters.
// Per-requester credit counters bound in-flight work; a tag pipeline routes results back.
module mult_sched #(
  parameter int WIDTH  = 64,
  parameter int NREQ   = 4,
  parameter int LAT    = WIDTH,
  parameter int MAXOUT = 8,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_y,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [2*WIDTH-1:0]      res_y,
  output logic                    busy
);

  localparam int CW = $clog2(MAXOUT + 1);

  logic [CW-1:0]    cnt_q [NREQ];
  logic [CW-1:0]    cnt_d [NREQ];
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [LAT:0]     vld_q, vld_d;
  logic [IDW-1:0]   id_q [LAT+1];
  logic [IDW-1:0]   id_d [LAT+1];

  logic [NREQ-1:0]   eligible;
  logic [2*NREQ-1:0] rot;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_id;
  logic [NREQ-1:0]   inc_vec, dec_vec;
  int                gnt_sum;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CW'(MAXOUT));
    end
  end

  // Rotating the doubled eligibility vector by ptr puts the search start at bit 0.
  always_comb begin
    rot       = {eligible, eligible} >> ptr_q;
    gnt_found = 1'b0;
    gnt_sum   = 0;
    gnt_id    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && rot[j]) begin
        gnt_found = 1'b1;
        gnt_sum   = int'(ptr_q) + j;
      end
    end
    if (gnt_sum >= NREQ) begin
      gnt_sum = gnt_sum - NREQ;
    end
    gnt_id = IDW'(gnt_sum);
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    ptr_d     = ptr_q;
    if (gnt_found) begin
      req_ready[gnt_id] = 1'b1;
      mul_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
      mul_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];
      ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  // The tag pipeline never stalls; its last stage lines up with mul_y.
  always_comb begin
    vld_d    = {vld_q[LAT-1:0], gnt_found};
    id_d[0]  = gnt_id;
    for (int i = 1; i <= LAT; i++) begin
      id_d[i] = id_q[i-1];
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc_vec[i] = gnt_found && (gnt_id == IDW'(i));
      dec_vec[i] = vld_q[LAT] && (id_q[LAT] == IDW'(i));
      cnt_d[i]   = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        id_q[i] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      for (int i = 0; i <= LAT; i++) begin
        id_q[i] <= id_d[i];
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign res_valid = vld_q[LAT];
  assign res_id    = id_q[LAT];
  assign res_y     = mul_y;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_mult_sched.sv
// Randomized self-checking bench for mult_sched: a queue-based reference model
// plus a latency-LAT multiplier model, with literal checks for key scenarios.
module tb_mult_sched;

  localparam int WIDTH  = 64;
  localparam int NREQ   = 4;
  localparam int LAT    = 64;
  localparam int MAXOUT = 8;
  localparam int IDW    = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_y;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [2*WIDTH-1:0]    res_y;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  mult_sched #(
    .WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .MAXOUT(MAXOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .res_valid(res_valid), .res_id(res_id), .res_y(res_y),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: operands sampled at edge k appear on mul_y after edge k+LAT.
  logic [2*WIDTH-1:0] mpipe [LAT+1];
  always @(posedge clk) begin
    mpipe[0] <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    for (int i = 1; i <= LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_y = mpipe[LAT];

  task automatic checkOutput(input string name, input logic [2*WIDTH-1:0] act,
                             input logic [2*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted op is queued with the negedge index at which
  // its result must be visible; outstanding counts follow from issue/return events.
  typedef struct {
    int                 due;
    int                 id;
    logic [2*WIDTH-1:0] prod;
  } op_t;

  op_t             q[$];
  int              cnt_m [NREQ];
  int              ptr_m = 0;
  int              n = 0;
  int              e_gnt;
  int              cand;
  logic [NREQ-1:0] e_rdy;
  logic [WIDTH-1:0] e_a, e_b;
  logic            e_rv;

  initial foreach (cnt_m[i]) cnt_m[i] = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      ptr_m = 0;
      foreach (cnt_m[i]) cnt_m[i] = 0;
    end
    e_gnt = -1;
    for (int j = 0; j < NREQ; j++) begin
      cand = (ptr_m + j) % NREQ;
      if (e_gnt < 0 && req_valid[cand] && cnt_m[cand] < MAXOUT) e_gnt = cand;
    end
    e_rdy = '0;
    e_a   = '0;
    e_b   = '0;
    if (e_gnt >= 0) begin
      e_rdy[e_gnt] = 1'b1;
      e_a = req_a[e_gnt*WIDTH +: WIDTH];
      e_b = req_b[e_gnt*WIDTH +: WIDTH];
    end
    e_rv = (q.size() > 0) && (q[0].due == n);
    checkOutput("req_ready", req_ready, e_rdy);
    checkOutput("mul_a", mul_a, e_a);
    checkOutput("mul_b", mul_b, e_b);
    checkOutput("res_valid", res_valid, e_rv);
    checkOutput("busy", busy, q.size() > 0);
    if (e_rv) begin
      checkOutput("res_id", res_id, q[0].id);
      checkOutput("res_y", res_y, q[0].prod);
    end
    for (int i = 0; i < NREQ; i++) begin
      checkOutput($sformatf("count%0d", i), dut.cnt_q[i], cnt_m[i]);
    end
    if (!rst) begin
      if (e_rv) begin
        cnt_m[q[0].id]--;
        void'(q.pop_front());
      end
      if (e_gnt >= 0) begin
        cnt_m[e_gnt]++;
        ptr_m = (e_gnt + 1) % NREQ;
        q.push_back('{due: n + LAT + 1, id: e_gnt,
                      prod: {{WIDTH{1'b0}}, e_a} * {{WIDTH{1'b0}}, e_b}});
      end
    end
    n++;
  end

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] a,
                               input logic [NREQ*WIDTH-1:0] b);
    @(posedge clk);
    #1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
  endtask

  function automatic logic [WIDTH-1:0] rndOp();
    case ($urandom_range(0, 7))
      0:       return {WIDTH{1'b1}};
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic randomOperands(output logic [NREQ*WIDTH-1:0] a, output logic [NREQ*WIDTH-1:0] b);
    for (int i = 0; i < NREQ; i++) begin
      a[i*WIDTH +: WIDTH] = rndOp();
      b[i*WIDTH +: WIDTH] = rndOp();
    end
  endtask

  // Asserts reset mid-cycle (between edges) for two clock edges.
  task automatic resetDut();
    @(posedge clk);
    #3;
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic drain();
    applyStimulus('0, '0, '0);
    repeat (LAT + 4) @(posedge clk);
  endtask

  task automatic directedOp(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2*WIDTH-1:0] exp);
    logic [NREQ*WIDTH-1:0] pa, pb;
    pa = '0;
    pb = '0;
    pa[id*WIDTH +: WIDTH] = a;
    pb[id*WIDTH +: WIDTH] = b;
    applyStimulus(NREQ'(1) << id, pa, pb);
    @(negedge clk);
    checkOutput("dir_ready", req_ready, NREQ'(1) << id);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    checkOutput("dir_busy_start", busy, 1);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("dir_res_early", res_valid, 0);
    checkOutput("dir_busy_mid", busy, 1);
    @(negedge clk);
    checkOutput("dir_res_valid", res_valid, 1);
    checkOutput("dir_res_id", res_id, id);
    checkOutput("dir_res_y", res_y, exp);
    @(negedge clk);
    checkOutput("dir_res_after", res_valid, 0);
    checkOutput("dir_busy_end", busy, 0);
  endtask

  logic [NREQ*WIDTH-1:0] ra, rb;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("init_res_valid", res_valid, 0);
    checkOutput("init_busy", busy, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    $display("[TB] directed single operations");
    directedOp(2, 64'd3, 64'd5, 128'd15);
    directedOp(1, {WIDTH{1'b1}}, {WIDTH{1'b1}}, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    directedOp(3, 64'd0, 64'hDEADBEEFCAFEF00D, 128'd0);

    $display("[TB] all requesters saturated");
    resetDut();
    for (int k = 0; k < 48; k++) begin
      randomOperands(ra, rb);
      applyStimulus('1, ra, rb);
      @(negedge clk);
      if (k < 8) checkOutput("rr_order", req_ready, NREQ'(1) << (k % NREQ));
    end
    drain();

    $display("[TB] credit limit on requester 0");
    resetDut();
    randomOperands(ra, rb);
    applyStimulus(NREQ'(1), ra, rb);
    for (int k = 0; k <= LAT + 8; k++) begin
      @(negedge clk);
      if (k < MAXOUT) checkOutput("credit_open", req_ready[0], 1);
      else if (k <= LAT + 1) checkOutput("credit_block", req_ready[0], 0);
      else checkOutput("credit_reopen", req_ready[0], 1);
      if (k == LAT + 1) checkOutput("credit_first_res", res_valid, 1);
    end
    drain();

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      randomOperands(ra, rb);
      applyStimulus(NREQ'($urandom), ra, rb);
    end
    drain();

    $display("[TB] reset in mid-flight");
    for (int k = 0; k < 5; k++) begin
      randomOperands(ra, rb);
      applyStimulus('1, ra, rb);
    end
    resetDut();
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      checkOutput("flush_res_valid", res_valid, 0);
      checkOutput("flush_busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
